// File: rtl/rice_block_scheduler.sv
// rtl/rice_block_scheduler.sv - fetches sample blocks, picks the block mode and hands each block to the Rice encoder
module rice_block_scheduler #(
    parameter int W           = 8,
    parameter int N           = 16,
    parameter int LOGN        = 4,
    parameter int D           = 8,
    parameter int LOGD        = 3,
    parameter int AW          = 8,
    parameter int MODE_THRESH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [AW-1:0]        base_addr,
    input  logic                 mode_auto,
    input  logic                 mode_cfg,
    output logic                 mem_rd_en,
    output logic [AW-1:0]        mem_addr,
    input  logic [W:0]           mem_rd_data,
    output logic                 enc_start,
    output logic                 enc_mode,
    output logic [N*(W+1)-1:0]   enc_data,
    input  logic                 enc_start_ack,
    input  logic                 enc_all_done,
    output logic                 busy,
    output logic [LOGD:0]        blocks_issued,
    output logic                 img_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ENC = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state, state_nx;
    logic [AW-1:0]       rd_ptr;
    logic [LOGN:0]       fetch_cnt;
    logic [W+LOGN-1:0]   acc;
    logic [W+LOGN-1:0]   sum_final;
    logic [W:0]          stage [N];
    logic                mode_r;
    logic [LOGD:0]       issued;
    logic [LOGD:0]       issued_inc;
    logic                busy_r;
    logic                done_r;
    logic                rd_phase;
    logic                last_cap;
    logic [LOGN-1:0]     cap_idx;

    // Reads occupy fetch cycles 0..N-1; each word lands one cycle later, so cycle N captures the last one.
    assign rd_phase   = (state == FETCH) && (fetch_cnt < (LOGN+1)'(N));
    assign last_cap   = (state == FETCH) && (fetch_cnt == (LOGN+1)'(N));
    assign cap_idx    = fetch_cnt[LOGN-1:0] - LOGN'(1);
    assign sum_final  = acc + {{LOGN{1'b0}}, mem_rd_data[W-1:0]};
    assign issued_inc = issued + (LOGD+1)'(1);

    assign mem_rd_en     = rd_phase;
    assign mem_addr      = rd_phase ? rd_ptr : '0;
    assign enc_start     = (state == ISSUE);
    assign enc_mode      = mode_r;
    assign busy          = busy_r;
    assign blocks_issued = issued;
    assign img_done      = done_r;

    always_comb begin
        enc_data = '0;
        for (int i = 0; i < N; i++) begin
            enc_data[(N-1-i)*(W+1) +: (W+1)] = stage[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (go) state_nx = FETCH;
            end
            FETCH: begin
                if (last_cap) state_nx = ISSUE;
            end
            ISSUE: begin
                if (enc_start_ack) begin
                    state_nx = (issued_inc == (LOGD+1)'(D)) ? WAIT_ENC : FETCH;
                end
            end
            WAIT_ENC: begin
                if (enc_all_done) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr    <= '0;
            fetch_cnt <= '0;
            acc       <= '0;
            mode_r    <= 1'b0;
            issued    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                stage[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        rd_ptr    <= base_addr;
                        issued    <= '0;
                        done_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        fetch_cnt <= '0;
                        acc       <= '0;
                    end
                end
                FETCH: begin
                    if (rd_phase) begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                    if (fetch_cnt != '0) begin
                        stage[cap_idx] <= mem_rd_data;
                        acc            <= sum_final;
                    end
                    if (last_cap) begin
                        fetch_cnt <= '0;
                        mode_r    <= mode_auto ? (sum_final >= (W+LOGN)'(MODE_THRESH)) : mode_cfg;
                    end else begin
                        fetch_cnt <= fetch_cnt + (LOGN+1)'(1);
                    end
                end
                ISSUE: begin
                    // Staging may be refilled right away: the encoder latched it on this accepting edge.
                    if (enc_start_ack) begin
                        issued <= issued_inc;
                        acc    <= '0;
                    end
                end
                WAIT_ENC: begin
                end
                DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rice_block_scheduler.sv
// tb/tb_rice_block_scheduler.sv - self-checking bench for rice_block_scheduler
module tb_rice_block_scheduler;
    localparam int W = 8, N = 16, LOGN = 4, D = 8, LOGD = 3, AW = 8, TH = 64;
    localparam int DW = N * (W + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            go = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic            mode_auto = 1'b0;
    logic            mode_cfg = 1'b0;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [W:0]      mem_rd_data = '0;
    logic            enc_start;
    logic            enc_mode;
    logic [DW-1:0]   enc_data;
    logic            enc_start_ack = 1'b0;
    logic            enc_all_done;
    logic            busy;
    logic [LOGD:0]   blocks_issued;
    logic            img_done;

    int errors = 0;
    int checks = 0;

    logic [W:0]      mem [256];
    int              ack_delay = 0;
    int              ack_cnt = 0;
    logic            model_done = 1'b0;
    logic            spur_done = 1'b0;
    int              done_wait = 0;
    int              acc_cnt = 0;
    logic [DW-1:0]   data_q [$];
    logic            mode_q [$];
    logic [AW-1:0]   addr_q [$];
    int              stall_viol = 0;
    int              rd_during_start = 0;
    logic            prev_start = 1'b0;
    logic            prev_busy = 1'b0;
    logic [DW-1:0]   held = '0;

    assign enc_all_done = model_done | spur_done;

    rice_block_scheduler #(
        .W(W), .N(N), .LOGN(LOGN), .D(D), .LOGD(LOGD), .AW(AW), .MODE_THRESH(TH)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .base_addr(base_addr),
        .mode_auto(mode_auto), .mode_cfg(mode_cfg),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .enc_start(enc_start), .enc_mode(enc_mode), .enc_data(enc_data),
        .enc_start_ack(enc_start_ack), .enc_all_done(enc_all_done),
        .busy(busy), .blocks_issued(blocks_issued), .img_done(img_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Encoder: ack ack_delay cycles after first seeing start, one-cycle pulse.
    always @(posedge clk) begin
        if (!enc_start || enc_start_ack) begin
            ack_cnt       <= 0;
            enc_start_ack <= 1'b0;
        end else if (ack_cnt >= ack_delay) begin
            enc_start_ack <= 1'b1;
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (acc_cnt != D) done_wait <= 0;
        else if (done_wait < 3) done_wait <= done_wait + 1;
        else if (done_wait == 3) begin
            model_done <= 1'b1;
            done_wait  <= 4;
        end
    end

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            data_q.delete();
            mode_q.delete();
            addr_q.delete();
            acc_cnt = 0;
        end
        if (mem_rd_en) addr_q.push_back(mem_addr);
        if (enc_start && enc_start_ack) begin
            data_q.push_back(enc_data);
            mode_q.push_back(enc_mode);
            acc_cnt++;
        end
        if (enc_start && prev_start && enc_data !== held) stall_viol++;
        if (enc_start && mem_rd_en) rd_during_start++;
        prev_start = enc_start;
        prev_busy  = busy;
        held       = enc_data;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int base, input int k);
        logic [DW-1:0] v = '0;
        for (int i = 0; i < N; i++) begin
            v[DW-1-i*(W+1) -: (W+1)] = mem[(base + k * N + i) % 256];
        end
        return v;
    endfunction

    function automatic logic exp_mode(input int base, input int k, input logic au, input logic cf);
        int s = 0;
        logic [W:0] w;
        for (int i = 0; i < N; i++) begin
            w = mem[(base + k * N + i) % 256];
            s += int'(w[W-1:0]);
        end
        return au ? (s >= TH) : cf;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_img(input int base, input logic au, input logic cf);
        @(negedge clk);
        base_addr = AW'(base);
        mode_auto = au;
        mode_cfg  = cf;
        go        = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!img_done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, img_done, 1);
    endtask

    task automatic check_img(input string tag, input int base, input logic au, input logic cf);
        int bad = 0;
        chk({tag, "_blocks_issued"}, blocks_issued, D);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_nblocks"}, data_q.size(), D);
        chk({tag, "_nreads"}, addr_q.size(), D * N);
        for (int k = 0; k < D; k++) begin
            if (k < data_q.size()) begin
                chk($sformatf("%s_data%0d", tag, k), data_q[k], exp_data(base, k));
                chk($sformatf("%s_mode%0d", tag, k), mode_q[k], exp_mode(base, k, au, cf));
            end
        end
        for (int j = 0; j < addr_q.size(); j++) begin
            if (addr_q[j] !== AW'((base + j) % 256)) bad++;
        end
        chk({tag, "_addr_seq"}, bad, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_start"}, enc_start, 0);
        chk({tag, "_mode"}, enc_mode, 0);
        chk({tag, "_data"}, enc_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_issued"}, blocks_issued, 0);
        chk({tag, "_img_done"}, img_done, 0);
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = {1'($urandom), 8'($urandom_range(0, 7))};
        end
    endtask

    initial begin
        logic [DW-1:0] d0;
        logic [DW-1:0] blk;
        logic [W:0]    slot;
        int            n;
        int            b;
        logic          cf;

        for (int i = 0; i < 256; i++) mem[i] = 9'(i);

        // reset
        cycles(3);
        check_zero("reset");
        rst = 1'b1;
        cycles(2);

        // fixed mode, memory[i]=i
        ack_delay = 0;
        start_img(0, 1'b0, 1'b1);
        wait_done("basic_done");
        check_img("basic", 0, 1'b0, 1'b1);
        if (data_q.size() > 0) begin
            blk  = data_q[0];
            slot = blk[DW-1 -: (W+1)];
            chk("basic_slot0", slot, 0);
            slot = blk[W:0];
            chk("basic_slot15", slot, 15);
        end

        // auto mode threshold: sum 63 vs 64, sign bits ignored
        rand_mem();
        for (int i = 0; i < 32; i++) mem[i] = 9'h100;
        mem[0]  = 9'h13f;
        mem[16] = 9'h140;
        start_img(0, 1'b1, 1'b0);
        wait_done("auto_done");
        check_img("auto", 0, 1'b1, 1'b0);
        if (mode_q.size() > 1) begin
            chk("auto_sum63", mode_q[0], 0);
            chk("auto_sum64", mode_q[1], 1);
        end

        // address wrap
        rand_mem();
        ack_delay = 2;
        start_img(250, 1'b1, 1'b0);
        wait_done("wrap_done");
        check_img("wrap", 250, 1'b1, 1'b0);

        // encoder stall of 200 cycles
        rand_mem();
        ack_delay = 200;
        b = int'($urandom_range(0, 255));
        start_img(b, 1'b0, 1'b0);
        n = 0;
        while (!enc_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_start_seen", enc_start, 1);
        d0 = enc_data;
        cycles(100);
        chk("stall_start_held", enc_start, 1);
        chk("stall_issued_0", blocks_issued, 0);
        chk("stall_data_held", enc_data, d0);
        chk("stall_no_read", mem_rd_en, 0);
        n = 0;
        while (blocks_issued == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("stall_issued_1", blocks_issued, 1);
        wait_done("stall_done");
        check_img("stall", b, 1'b0, 1'b0);
        chk("stall_data_changes", stall_viol, 0);
        chk("stall_reads_in_issue", rd_during_start, 0);

        // reset during FETCH of block 3, then restart
        rand_mem();
        ack_delay = 1;
        b = int'($urandom_range(0, 255));
        start_img(b, 1'b1, 1'b0);
        n = 0;
        while (!(blocks_issued == 3 && mem_rd_en) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached", blocks_issued, 3);
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b1;
        cycles(5);
        chk("midrst_idle_rd", mem_rd_en, 0);
        chk("midrst_idle_busy", busy, 0);
        b = int'($urandom_range(0, 255));
        start_img(b, 1'b1, 1'b0);
        wait_done("restart_done");
        check_img("restart", b, 1'b1, 1'b0);

        // go while busy and early enc_all_done are ignored
        rand_mem();
        ack_delay = int'($urandom_range(0, 3));
        b  = int'($urandom_range(0, 255));
        cf = 1'($urandom);
        start_img(b, 1'b0, cf);
        n = 0;
        while (blocks_issued != 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        base_addr = AW'(b + 77);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (blocks_issued != 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("spur_reached5", blocks_issued, 5);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        cycles(3);
        chk("spur_no_done", img_done, 0);
        chk("spur_busy", busy, 1);
        wait_done("spur_done");
        check_img("spur", b, 1'b0, cf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
